// File: rtl/record_fn_arbiter.sv
// Round-robin arbiter over N_CH {x, y} record producers, computing a saturating or
// wrapping y+x and returning it tagged with its source channel over a sync/notify handshake.
module record_fn_arbiter #(
    parameter int N_CH  = 4,
    parameter int DW    = 32,
    parameter int MODE  = 0,
    parameter int CNT_W = 16,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   b_in_x,
    input  logic [N_CH*DW-1:0]   b_in_y,
    input  logic [N_CH-1:0]      b_in_sync,
    output logic [N_CH-1:0]      b_in_notify,
    output logic [DW-1:0]        b_out,
    output logic [CH_W-1:0]      b_out_ch,
    input  logic                 b_out_sync,
    output logic                 b_out_notify,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int CW1 = CH_W + 1;

    typedef enum logic [1:0] {READ, COMPUTE, WRITE} state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [DW-1:0]    x_q, x_d, y_q, y_d;
    logic [DW-1:0]    b_out_q, b_out_d;
    logic [CH_W-1:0]  b_out_ch_q, b_out_ch_d;
    logic             b_out_notify_q, b_out_notify_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic             gnt_vld;
    logic [CH_W-1:0]  gnt_idx;
    logic [CW1-1:0]   cand;
    logic [DW+1:0]    sum;
    logic [DW-1:0]    result;

    // Scan from rr_ptr upward with wrap; the first requesting channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, rr_ptr_q} + CW1'(k);
            if (cand >= CW1'(N_CH)) cand = cand - CW1'(N_CH);
            if (!gnt_vld && b_in_sync[cand[CH_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[CH_W-1:0];
            end
        end
    end

    assign b_in_notify = (state_q == READ && !rst && gnt_vld) ? (N_CH'(1) << gnt_idx) : '0;

    // Two guard bits keep the sign of x+y unambiguous for the saturation decision.
    always_comb begin
        sum    = {{2{x_q[DW-1]}}, x_q} + {2'b00, y_q};
        result = sum[DW-1:0];
        if (MODE == 0) begin
            if (sum[DW+1])  result = '0;
            else if (sum[DW]) result = '1;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        ch_d           = ch_q;
        x_d            = x_q;
        y_d            = y_q;
        b_out_d        = b_out_q;
        b_out_ch_d     = b_out_ch_q;
        b_out_notify_d = b_out_notify_q;
        xfer_cnt_d     = xfer_cnt_q;
        case (state_q)
            READ: begin
                if (gnt_vld) begin
                    x_d      = b_in_x[gnt_idx*DW +: DW];
                    y_d      = b_in_y[gnt_idx*DW +: DW];
                    ch_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                b_out_d        = result;
                b_out_ch_d     = ch_q;
                b_out_notify_d = 1'b1;
                state_d        = WRITE;
            end
            WRITE: begin
                if (b_out_sync) begin
                    b_out_notify_d = 1'b0;
                    xfer_cnt_d     = xfer_cnt_q + 1'b1;
                    state_d        = READ;
                end
            end
            default: state_d = READ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= READ;
            rr_ptr_q       <= '0;
            ch_q           <= '0;
            x_q            <= '0;
            y_q            <= '0;
            b_out_q        <= '0;
            b_out_ch_q     <= '0;
            b_out_notify_q <= 1'b0;
            xfer_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            ch_q           <= ch_d;
            x_q            <= x_d;
            y_q            <= y_d;
            b_out_q        <= b_out_d;
            b_out_ch_q     <= b_out_ch_d;
            b_out_notify_q <= b_out_notify_d;
            xfer_cnt_q     <= xfer_cnt_d;
        end
    end

    assign b_out        = b_out_q;
    assign b_out_ch     = b_out_ch_q;
    assign b_out_notify = b_out_notify_q;
    assign xfer_cnt     = xfer_cnt_q;

endmodule
